// File: rtl/square1_anim_ctrl.sv
// square1 animation sequencer and double-buffered trail palette.
// Frame and palette updates land together on the vsync-derived boundary tick.
module square1_anim_ctrl #(
  parameter int N_LAG = 15,
  parameter int FW    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              run,
  input  logic              dir,
  input  logic              step,
  input  logic [2:0]        speed,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_addr,
  input  logic [2:0]        cfg_data,
  input  logic              cfg_commit,
  output logic [FW-1:0]     frame_no,
  output logic              frame_tick,
  output logic [3*N_LAG-1:0] palette,
  output logic [1:0]        state
);

  localparam int PW = 3 * N_LAG;

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_RUN   = 2'd1,
    S_ARMED = 2'd2
  } st_e;

  function automatic logic [PW-1:0] dflt_pal();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < N_LAG; i++) begin
      if (i == 0)      p[3*i +: 3] = 3'b011;
      else if (i <= 2) p[3*i +: 3] = 3'b111;
      else if (i <= 6) p[3*i +: 3] = 3'b110;
      else             p[3*i +: 3] = 3'b101;
    end
    return p;
  endfunction

  localparam logic [PW-1:0] DEF_PAL = dflt_pal();

  // control pins: {speed, step, dir, run}
  logic [5:0] ctl_s1_q, ctl_s2_q;
  logic       step_prev_q;
  logic       vs_q;

  logic       run_s, dir_s, step_s;
  logic [2:0] speed_s;
  logic       step_edge, bnd;

  assign run_s     = ctl_s2_q[0];
  assign dir_s     = ctl_s2_q[1];
  assign step_s    = ctl_s2_q[2];
  assign speed_s   = ctl_s2_q[5:3];
  assign step_edge = step_s & ~step_prev_q;
  assign bnd       = vsync & ~vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_s1_q    <= '0;
      ctl_s2_q    <= '0;
      step_prev_q <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      ctl_s1_q    <= {speed, step, dir, run};
      ctl_s2_q    <= ctl_s1_q;
      step_prev_q <= step_s;
      vs_q        <= vsync;
    end
  end

  st_e           st_q, st_d;
  logic [2:0]    div_q, div_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          tick_q;
  logic          adv;

  always_comb begin
    st_d    = st_q;
    div_d   = div_q;
    frame_d = frame_q;
    adv     = 1'b0;
    unique case (st_q)
      S_PAUSE: begin
        if (run_s) begin
          st_d  = S_RUN;
          div_d = 3'd0;
        end else if (step_edge) begin
          st_d = S_ARMED;
        end
      end
      S_RUN: begin
        if (!run_s) begin
          st_d = S_PAUSE;
        end else if (bnd) begin
          if (div_q == speed_s) begin
            adv   = 1'b1;
            div_d = 3'd0;
          end else begin
            div_d = div_q + 3'd1;
          end
        end
      end
      S_ARMED: begin
        if (run_s) begin
          st_d  = S_RUN;
          div_d = 3'd0;
        end else if (bnd) begin
          adv   = 1'b1;
          div_d = 3'd0;
          st_d  = S_PAUSE;
        end
      end
      default: st_d = S_PAUSE;
    endcase
    if (adv)
      frame_d = dir_s ? frame_q - FW'(1) : frame_q + FW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_PAUSE;
      div_q   <= 3'd0;
      frame_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      div_q   <= div_d;
      frame_q <= frame_d;
      tick_q  <= bnd;
    end
  end

  logic [PW-1:0] shadow_q, shadow_d;
  logic [PW-1:0] act_q, act_d;
  logic          pend_q, pend_d;
  logic          rdy_q, rdy_d;

  // a pending commit only fires on a boundary after the one it arrived with
  always_comb begin
    shadow_d = shadow_q;
    act_d    = act_q;
    pend_d   = pend_q;
    if (cfg_valid && rdy_q) begin
      for (int i = 0; i < N_LAG; i++) begin
        if (cfg_addr == 4'(i))
          shadow_d[3*i +: 3] = cfg_data;
      end
    end
    if (bnd && pend_q) begin
      act_d  = shadow_q;
      pend_d = 1'b0;
    end else if (cfg_commit && rdy_q) begin
      pend_d = 1'b1;
    end
    rdy_d = ~pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DEF_PAL;
      act_q    <= DEF_PAL;
      pend_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      rdy_q    <= rdy_d;
    end
  end

  assign frame_no   = frame_q;
  assign frame_tick = tick_q;
  assign palette    = act_q;
  assign state      = st_q;
  assign cfg_ready  = rdy_q;

endmodule

// File: tb/tb_square1_anim_ctrl.sv
// Scoreboard bench for square1_anim_ctrl: each vsync pushes the expected
// frame/palette, a monitor pops and compares on every frame_tick.
module tb_square1_anim_ctrl;

  localparam int N_LAG = 15;
  localparam int FW    = 9;
  localparam int PW    = 3 * N_LAG;

  localparam logic [PW-1:0] DEF =
    {{8{3'b101}}, {4{3'b110}}, {2{3'b111}}, 3'b011};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync, run, dir, step;
  logic [2:0]    speed;
  logic          cfg_valid, cfg_ready, cfg_commit;
  logic [3:0]    cfg_addr;
  logic [2:0]    cfg_data;
  logic [FW-1:0] frame_no;
  logic          frame_tick;
  logic [PW-1:0] palette;
  logic [1:0]    state;

  square1_anim_ctrl #(.N_LAG(N_LAG), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync),
    .run(run), .dir(dir), .step(step), .speed(speed),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit),
    .frame_no(frame_no), .frame_tick(frame_tick),
    .palette(palette), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] f;
    logic [PW-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_tick) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL tick_unexpected: got tick frame %0d expected none",
                 frame_no);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tick_frame", 64'(frame_no), 64'(mon_e.f));
        chk("tick_palette", 64'(palette), 64'(mon_e.p));
      end
    end
  end

  function automatic logic [PW-1:0] set_ent(logic [PW-1:0] p, int i,
                                            logic [2:0] v);
    logic [PW-1:0] r;
    r = p;
    r[3*i +: 3] = v;
    return r;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs(logic [FW-1:0] f, logic [PW-1:0] p);
    exp_q.push_back({f, p});
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc(4);
    step = 1'b0;
    cyc(4);
  endtask

  logic [FW-1:0] t2_exp [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
  logic [PW-1:0] p1, p2;

  initial begin
    rst_n = 1'b0; vsync = 1'b0; run = 1'b0; dir = 1'b0;
    step = 1'b0; speed = 3'd0; cfg_valid = 1'b0;
    cfg_commit = 1'b0; cfg_addr = 4'd0; cfg_data = 3'd0;
    cyc(3);
    chk("rst_frame", 64'(frame_no), 64'd0);
    chk("rst_tick", 64'(frame_tick), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd1);
    chk("rst_palette", 64'(palette), 64'(DEF));
    rst_n = 1'b1;
    cyc(2);

    // run at full speed
    run = 1'b1;
    cyc(5);
    chk("t1_state_run", 64'(state), 64'd1);
    vs(1, DEF);
    vs(2, DEF);
    vs(3, DEF);
    chk("t1_frame_end", 64'(frame_no), 64'd3);

    // speed divider 3
    speed = 3'd2;
    do_reset();
    cyc(5);
    for (int i = 0; i < 9; i++) vs(t2_exp[i], DEF);
    chk("t2_frame_end", 64'(frame_no), 64'd3);

    // single step backwards
    run = 1'b0; speed = 3'd0; dir = 1'b1;
    do_reset();
    cyc(5);
    chk("t3_state_pause", 64'(state), 64'd0);
    pulse_step();
    chk("t3_state_armed", 64'(state), 64'd2);
    pulse_step();
    chk("t3_state_armed2", 64'(state), 64'd2);
    vs(511, DEF);
    chk("t3_state_back", 64'(state), 64'd0);
    vs(511, DEF);
    chk("t3_frame_end", 64'(frame_no), 64'd511);

    // palette write, out-of-range write, commit
    dir = 1'b0;
    do_reset();
    cyc(5);
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 3'b100;
    cyc(1);
    cfg_addr = 4'd15; cfg_data = 3'b000;
    cyc(1);
    cfg_valid = 1'b0; cfg_commit = 1'b1;
    cyc(1);
    cfg_commit = 1'b0;
    cyc(1);
    chk("t4_ready_low", 64'(cfg_ready), 64'd0);
    chk("t4_pal0_before", 64'(palette[2:0]), 64'(3'b011));
    p1 = set_ent(DEF, 0, 3'b100);
    vs(0, p1);
    chk("t4_ready_high", 64'(cfg_ready), 64'd1);
    chk("t4_palette", 64'(palette), 64'(p1));

    // commit coincident with a boundary is deferred
    cfg_valid = 1'b1; cfg_addr = 4'd1; cfg_data = 3'b010;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(1);
    exp_q.push_back({FW'(0), p1});
    vsync = 1'b1; cfg_commit = 1'b1;
    cyc(1);
    cfg_commit = 1'b0;
    cyc(1);
    vsync = 1'b0;
    chk("t5_ready_low", 64'(cfg_ready), 64'd0);
    cyc(3);
    chk("t5_pal_held", 64'(palette), 64'(p1));
    p2 = set_ent(p1, 1, 3'b010);
    vs(0, p2);
    chk("t5_ready_high", 64'(cfg_ready), 64'd1);

    // async reset with a commit pending
    run = 1'b1;
    cyc(5);
    vs(1, p2);
    cfg_valid = 1'b1; cfg_addr = 4'd2; cfg_data = 3'b000;
    cfg_commit = 1'b1;
    cyc(1);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    cyc(1);
    chk("t6_ready_low", 64'(cfg_ready), 64'd0);
    chk("t6_state_run", 64'(state), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_frame", 64'(frame_no), 64'd0);
    chk("t6_palette", 64'(palette), 64'(DEF));
    chk("t6_ready", 64'(cfg_ready), 64'd1);
    chk("t6_state", 64'(state), 64'd0);
    run = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL sb_drain: got %0d ticks outstanding expected 0",
               exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
